spi_host_ctrl: RTL and testbench
================================

// Module: spi_host_ctrl
// PURPOSE
//  Single SPI host that shares one spi_device link between NUM_REQ on-chip requesters.
//  Each requester issues one register access (addr, dir, wdata) over a valid/ready handshake.
//  A round-robin arbiter picks the next requester, and the block serialises a command+data frame.
//  Read data returns on a shared rsp_rdata bus with a per-requester rsp_valid pulse.
// PARAMETERS
//  NUM_REQ         2  number of requesters (>=1)
//  SPI_CMD_WIDTH   8  command field length in bits
//  SPI_DATA_WIDTH  8  data field length in bits
//  SPI_ADDR_WIDTH  3  register address width (< SPI_CMD_WIDTH)
//  CLK_DIV         4  spi_clk half-period in clk cycles (>=1)
// PORTS
//  clk        in   1                     system clock; all logic on posedge
//  rst        in   1                     synchronous, active-high reset
//  req_valid  in   NUM_REQ               request pending, one bit per requester
//  req_ready  out  NUM_REQ               one-cycle grant pulse; request is consumed on valid&ready
//  req_addr   in   NUM_REQ*SPI_ADDR_WIDTH  register address; requester i uses slice i
//  req_dir    in   NUM_REQ               1 = write, 0 = read
//  req_wdata  in   NUM_REQ*SPI_DATA_WIDTH  write data; requester i uses slice i
//  rsp_valid  out  NUM_REQ               one-cycle completion pulse to the owning requester
//  rsp_rdata  out  SPI_DATA_WIDTH        read data; valid while rsp_valid is high; 0 for writes
//  busy       out  1                     high from grant until the end of GAP
//  spi_clk    out  1                     SPI clock; idles low
//  spi_sel    out  1                     active-low select; high when idle
//  spi_mosi   out  1                     host-to-device serial data
//  spi_miso   in   1                     device-to-host serial data
// BEHAVIOUR
//  Reset values: spi_sel=1, spi_clk=0, spi_mosi=0, req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0.
//  Reset also clears the FSM and the divider, and sets the RR pointer to 0.
//  Reset mid-frame aborts the frame: spi_sel goes high on the next edge and no rsp_valid is issued.
//  Frame: cmd word = {zeros, addr, dir}, so bit0 = dir and bits [SPI_ADDR_WIDTH:1] = addr.
//  The frame sends SPI_CMD_WIDTH cmd bits, then SPI_DATA_WIDTH data bits, all LSB first.
//  Mode 0 timing:
//   - spi_mosi changes only while spi_clk is low.
//   - spi_miso is sampled on the clk cycle in which spi_clk rises.
//   - Each bit lasts 2*CLK_DIV clk cycles: CLK_DIV cycles low, then CLK_DIV cycles high.
//  In a write frame, data bits carry the wdata slice. In a read frame, mosi=0 and the miso data bits are shifted in.
//  FSM states:
//   - IDLE: sel=1. If any req_valid is set, grant the RR winner: req_ready[w]=1 for one cycle.
//     Latch addr, dir and wdata for w, go to SETUP, and set busy=1.
//   - SETUP: sel=0, clk=0, mosi=cmd bit0, held for CLK_DIV cycles. Then go to SHIFT.
//   - SHIFT: SPI_CMD_WIDTH+SPI_DATA_WIDTH bit periods, counted by a bit counter of width
//     $clog2(SPI_CMD_WIDTH+SPI_DATA_WIDTH+1). After the last high phase, drop clk and go to HOLD.
//   - HOLD: sel=0, clk=0 for CLK_DIV cycles. In the last HOLD cycle, rsp_valid[w]=1 and rsp_rdata is driven.
//     Then go to GAP.
//   - GAP: sel=1 for 2*CLK_DIV cycles, which guarantees the device returns to its idle state. Then go to IDLE with busy=0.
//  Arbitration: round-robin starting from ptr. After a grant to w, ptr = (w+1) mod NUM_REQ.
//   - Requests are sampled only in IDLE. A req_valid raised mid-frame waits.
//   - Requesters must hold valid, addr, dir and wdata stable until ready.
//   - Deasserting valid before ready is allowed and withdraws the request.
//  Simultaneous events:
//   - At most one req_ready bit is set per cycle.
//   - rsp_valid and req_ready never coincide, because GAP separates them.
//   - Back-to-back grants are at least 1 + CLK_DIV*(2*(CMD+DATA)+4) cycles apart.
//  Per-frame latency from grant to rsp_valid: CLK_DIV*(2*(SPI_CMD_WIDTH+SPI_DATA_WIDTH)+2) cycles.
// STRUCTURE
//  spi_defs.vh holds the shared definitions:
//   - state encodings IDLE/SETUP/SHIFT/HOLD/GAP;
//   - the cmd bit positions (DIR_BIT=0, ADDR_LSB=1);
//   - a frame-length macro, which spi_device also uses.
//  Sub-module spi_rr_arbiter(NUM_REQ): inputs req, ptr; outputs grant_onehot, grant_idx, any.
//  The arbiter is purely combinational. ptr is a register in spi_host_ctrl.
//  The top level contains the divider counter, bit counter, FSM, tx shift register (cmd,wdata) and rx shift register.
// TESTING
//  Bench: spi_host_ctrl connected to spi_device + spi_register, with NUM_REQ=2 and CLK_DIV=2.
//  1) Write: req0 addr=3, dir=1, wdata=8'hA5.
//     -> mosi carries cmd 8'h07 then A5, LSB first. rsp_valid[0] arrives 68 cycles after grant.
//     -> The register at address 3 reads back A5.
//  2) Read: miso model returns 8'h3C, req1 addr=5, dir=0.
//     -> rsp_valid[1] pulses with rsp_rdata=8'h3C. mosi stays 0 during the data bits.
//  3) Fairness: req0 and req1 both held valid for 4 frames -> grants alternate 0,1,0,1 and busy never drops mid-frame.
//  4) Reset at bit 5 of the cmd field -> the next cycle shows sel=1, clk=0, no rsp_valid.
//     -> A new req0 frame then completes normally.
//  5) Withdraw: req1 valid is dropped before grant while req0 is pending -> only req0 is granted, with no rsp_valid[1].
//  6) Protocol checks on every frame:
//     -> mosi stable while spi_clk is high; 16 rising spi_clk edges per frame.
//     -> sel high for at least 4 cycles between frames.

Source files
------------

// File: rtl/spi_host_ctrl_pkg.sv
// Shared definitions for the SPI host controller: FSM states, command word
// bit positions and small sizing helpers.
package spi_host_ctrl_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  // Command word layout: {zeros, addr, dir}.
  localparam int DIR_BIT  = 0;
  localparam int ADDR_LSB = 1;

  // Number of serial bits in one command+data frame.
  function automatic int frame_len(input int cmd_w, input int data_w);
    return cmd_w + data_w;
  endfunction

  // Width of a requester index; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_host_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps,
// returning the first asserted request as both a one-hot vector and an index.
module spi_rr_arbiter
  import spi_host_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  // Scan requesters from ptr upwards (wrapping) and take the first one pending.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!any && req[(int'(ptr) + off) % NUM_REQ]) begin
        any = 1'b1;
        grant_idx = IDX_W'((int'(ptr) + off) % NUM_REQ);
        grant_onehot[(int'(ptr) + off) % NUM_REQ] = 1'b1;
      end else begin
      end
    end
  end

endmodule

// File: rtl/spi_host_ctrl.sv
// SPI host shared by NUM_REQ requesters. One register access per grant is
// serialised as a mode-0 command+data frame, LSB first, with read data
// returned on a shared bus and a per-requester completion pulse.
module spi_host_ctrl
  import spi_host_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int SPI_CMD_WIDTH  = 8,
  parameter int SPI_DATA_WIDTH = 8,
  parameter int SPI_ADDR_WIDTH = 3,
  parameter int CLK_DIV        = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*SPI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]                  req_dir,
  input  logic [NUM_REQ*SPI_DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [SPI_DATA_WIDTH-1:0]           rsp_rdata,
  output logic                                busy,
  output logic                                spi_clk,
  output logic                                spi_sel,
  output logic                                spi_mosi,
  input  logic                                spi_miso
);

  localparam int TOTAL = frame_len(SPI_CMD_WIDTH, SPI_DATA_WIDTH);
  localparam int BIT_W = $clog2(TOTAL + 1);
  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int IDX_W = idx_width(NUM_REQ);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TOTAL - 1);
  localparam logic [BIT_W-1:0] CMD_BITS = BIT_W'(SPI_CMD_WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  spi_state_e                state_r;
  logic [DIV_W-1:0]          div_cnt_r;
  logic [BIT_W-1:0]          bit_cnt_r;
  logic                      phase_r;
  logic [TOTAL-2:0]          tx_sr_r;
  logic [SPI_DATA_WIDTH-1:0] rx_sr_r;
  logic [IDX_W-1:0]          owner_r;
  logic                      dir_r;
  logic [IDX_W-1:0]          ptr_r;

  logic [NUM_REQ-1:0]        grant_onehot_s;
  logic [IDX_W-1:0]          grant_idx_s;
  logic                      any_s;
  logic [SPI_ADDR_WIDTH-1:0] win_addr_s;
  logic                      win_dir_s;
  logic [SPI_DATA_WIDTH-1:0] win_wdata_s;
  logic [SPI_CMD_WIDTH-1:0]  win_cmd_s;
  logic [TOTAL-1:0]          tx_word_s;

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req          (req_valid),
    .ptr          (ptr_r),
    .grant_onehot (grant_onehot_s),
    .grant_idx    (grant_idx_s),
    .any          (any_s)
  );

  // Build the outgoing frame for the arbitration winner; reads send zero data bits.
  always_comb begin
    win_addr_s  = req_addr[int'(grant_idx_s) * SPI_ADDR_WIDTH +: SPI_ADDR_WIDTH];
    win_dir_s   = req_dir[grant_idx_s];
    win_wdata_s = req_wdata[int'(grant_idx_s) * SPI_DATA_WIDTH +: SPI_DATA_WIDTH];
    win_cmd_s   = '0;
    win_cmd_s[ADDR_LSB +: SPI_ADDR_WIDTH] = win_addr_s;
    win_cmd_s[DIR_BIT] = win_dir_s;
    if (win_dir_s) begin
      tx_word_s = {win_wdata_s, win_cmd_s};
    end else begin
      tx_word_s = {{SPI_DATA_WIDTH{1'b0}}, win_cmd_s};
    end
  end

  // Frame sequencer: arbitration, clock division, serialisation and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      div_cnt_r <= '0;
      bit_cnt_r <= '0;
      phase_r   <= 1'b0;
      tx_sr_r   <= '0;
      rx_sr_r   <= '0;
      owner_r   <= '0;
      dir_r     <= 1'b0;
      ptr_r     <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      spi_clk   <= 1'b0;
      spi_sel   <= 1'b1;
      spi_mosi  <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      case (state_r)
        ST_IDLE: begin
          spi_sel  <= 1'b1;
          spi_clk  <= 1'b0;
          spi_mosi <= 1'b0;
          busy     <= 1'b0;
          if (any_s) begin
            // Bit 0 goes straight onto mosi; the rest waits in the shifter.
            req_ready <= grant_onehot_s;
            owner_r   <= grant_idx_s;
            dir_r     <= win_dir_s;
            tx_sr_r   <= tx_word_s[TOTAL-1:1];
            spi_mosi  <= tx_word_s[0];
            spi_sel   <= 1'b0;
            busy      <= 1'b1;
            ptr_r     <= (grant_idx_s == IDX_LAST) ? '0 : grant_idx_s + IDX_W'(1);
            div_cnt_r <= '0;
            state_r   <= ST_SETUP;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            bit_cnt_r <= '0;
            phase_r   <= 1'b0;
            state_r   <= ST_SHIFT;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        ST_SHIFT: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            if (!phase_r) begin
              // Rising edge: the device has held miso stable through the low phase.
              spi_clk <= 1'b1;
              phase_r <= 1'b1;
              if (bit_cnt_r >= CMD_BITS) begin
                rx_sr_r <= {spi_miso, rx_sr_r[SPI_DATA_WIDTH-1:1]};
              end else begin
                rx_sr_r <= rx_sr_r;
              end
            end else begin
              // Falling edge: mosi moves to the next bit together with clk going low.
              spi_clk <= 1'b0;
              phase_r <= 1'b0;
              if (bit_cnt_r == BIT_LAST) begin
                spi_mosi <= 1'b0;
                state_r  <= ST_HOLD;
                if (CLK_DIV == 1) begin
                  rsp_valid[owner_r] <= 1'b1;
                  rsp_rdata <= dir_r ? {SPI_DATA_WIDTH{1'b0}} : rx_sr_r;
                end else begin
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                spi_mosi  <= tx_sr_r[0];
                tx_sr_r   <= {1'b0, tx_sr_r[TOTAL-2:1]};
              end
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        ST_HOLD: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            spi_sel   <= 1'b1;
            state_r   <= ST_GAP;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
            // Raise the response so it is visible during the final HOLD cycle.
            if ((div_cnt_r + DIV_W'(1)) == DIV_LAST) begin
              rsp_valid[owner_r] <= 1'b1;
              rsp_rdata <= dir_r ? {SPI_DATA_WIDTH{1'b0}} : rx_sr_r;
            end else begin
            end
          end
        end
        ST_GAP: begin
          spi_sel <= 1'b1;
          if (div_cnt_r == GAP_LAST) begin
            div_cnt_r <= '0;
            busy      <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        default: begin
          div_cnt_r <= '0;
          spi_sel   <= 1'b1;
          spi_clk   <= 1'b0;
          spi_mosi  <= 1'b0;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host_ctrl.sv
// Directed bench for spi_host_ctrl with a behavioural SPI register device.
module tb_spi_host_ctrl;

  localparam int NUM_REQ   = 2;
  localparam int CMD_W     = 8;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 3;
  localparam int CLK_DIV   = 2;
  localparam int FRAME_LAT = CLK_DIV * (2 * (CMD_W + DATA_W) + 2);

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic [NUM_REQ-1:0]          req_valid = '0;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*ADDR_W-1:0]   req_addr = '0;
  logic [NUM_REQ-1:0]          req_dir = '0;
  logic [NUM_REQ*DATA_W-1:0]   req_wdata = '0;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic [DATA_W-1:0]           rsp_rdata;
  logic                        busy;
  logic                        spi_clk;
  logic                        spi_sel;
  logic                        spi_mosi;
  logic                        spi_miso;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  spi_host_ctrl #(
    .NUM_REQ        (NUM_REQ),
    .SPI_CMD_WIDTH  (CMD_W),
    .SPI_DATA_WIDTH (DATA_W),
    .SPI_ADDR_WIDTH (ADDR_W),
    .CLK_DIV        (CLK_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_dir   (req_dir),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .spi_clk   (spi_clk),
    .spi_sel   (spi_sel),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- behavioural SPI register device ----------------
  logic [4:0]  dev_rises   = '0;
  logic [15:0] dev_frame   = '0;
  logic [15:0] last_frame  = '0;
  logic [7:0]  dev_regs [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00};
  logic [7:0]  dev_rd_byte;
  logic        mon_en      = 1'b0;
  logic        abort_frame = 1'b0;

  assign dev_rd_byte = dev_regs[dev_frame[3:1]];
  assign spi_miso = (!spi_sel && dev_rises >= 5'd8 && dev_rises < 5'd16 && !dev_frame[0])
                    ? dev_rd_byte[dev_rises[2:0]] : 1'b0;

  always @(posedge spi_clk or negedge spi_sel) begin
    if (!spi_sel && spi_clk) begin
      if (dev_rises < 5'd16) dev_frame[dev_rises[3:0]] <= spi_mosi;
      dev_rises <= dev_rises + 5'd1;
    end else if (!spi_sel) begin
      dev_rises <= '0;
      dev_frame <= '0;
    end
  end

  always @(posedge spi_sel) begin
    if (mon_en && !abort_frame) begin
      check("rises_per_frame", 32'(dev_rises), 32'd16);
      last_frame <= dev_frame;
      if (dev_frame[0]) dev_regs[dev_frame[3:1]] <= dev_frame[15:8];
    end
  end

  // ---------------- protocol monitors ----------------
  logic prev_sclk  = 1'b0;
  logic prev_mosi  = 1'b0;
  logic prev_sel   = 1'b1;
  logic seen_frame = 1'b0;
  int   sel_run    = 0;
  int   rsp1_cnt   = 0;

  always @(negedge clk) begin
    if (mon_en && prev_sclk && spi_clk) check("mosi_stable_high", 32'(spi_mosi), 32'(prev_mosi));
    if (mon_en && prev_sel && !spi_sel && seen_frame) check("sel_gap_ge4", 32'(sel_run >= 4), 32'd1);
    if (rsp_valid[1]) rsp1_cnt <= rsp1_cnt + 1;
    sel_run    <= spi_sel ? sel_run + 1 : 0;
    seen_frame <= seen_frame | (mon_en & !spi_sel);
    prev_sclk  <= spi_clk;
    prev_mosi  <= spi_mosi;
    prev_sel   <= spi_sel;
  end

  // Wait for the grant, optionally withdraw the request, then wait for the response.
  task automatic run_frame(input int exp_gnt, input logic hold, output logic [7:0] rdata, output int lat);
    int waited;
    logic busy_ok;
    logic [1:0] exp_oh;
    exp_oh = (exp_gnt == 0) ? 2'b01 : 2'b10;
    waited = 0;
    while (req_ready == 2'b00 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("grant", 32'(req_ready), 32'(exp_oh));
    if (!hold) req_valid[exp_gnt] = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (rsp_valid == 2'b00 && lat < 300) begin
      busy_ok = busy_ok & busy;
      @(negedge clk);
      lat++;
    end
    check("busy_in_frame", 32'(busy_ok & busy), 32'd1);
    check("rsp_owner", 32'(rsp_valid), 32'(exp_oh));
    rdata = rsp_rdata;
  endtask

  initial begin
    logic [7:0] rd;
    int lat;
    int waited;
    int r1_before;
    logic rsp_any;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_sel", 32'(spi_sel), 32'd1);
    check("rst_sclk", 32'(spi_clk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // 1) Write req0 addr 3 = A5
    req_addr[2:0] = 3'd3; req_dir[0] = 1'b1; req_wdata[7:0] = 8'hA5;
    req_valid = 2'b01;
    run_frame(0, 1'b0, rd, lat);
    check("wr_latency", 32'(lat), 32'(FRAME_LAT));
    check("wr_rdata_zero", 32'(rd), 32'd0);
    repeat (3) @(negedge clk);
    check("wr_cmd_bits", 32'(last_frame[7:0]), 32'h07);
    check("wr_data_bits", 32'(last_frame[15:8]), 32'hA5);
    // readback of address 3
    req_dir[0] = 1'b0;
    req_valid = 2'b01;
    run_frame(0, 1'b0, rd, lat);
    check("readback_a5", 32'(rd), 32'hA5);

    // 2) Read req1 addr 5 -> 3C
    req_addr[5:3] = 3'd5; req_dir[1] = 1'b0;
    req_valid = 2'b10;
    run_frame(1, 1'b0, rd, lat);
    check("rd_data_3c", 32'(rd), 32'h3C);
    repeat (3) @(negedge clk);
    check("rd_cmd_bits", 32'(last_frame[7:0]), 32'h0A);
    check("rd_mosi_zero", 32'(last_frame[15:8]), 32'h00);

    // 3) Fairness with both requesters held valid
    req_addr = {3'd6, 3'd2}; req_dir = 2'b11; req_wdata = {8'h22, 8'h11};
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      run_frame(i % 2, 1'b1, rd, lat);
    end
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    check("fair_reg2", 32'(dev_regs[2]), 32'h11);
    check("fair_reg6", 32'(dev_regs[6]), 32'h22);

    // 4) Reset during cmd bit 5
    req_addr[2:0] = 3'd4; req_dir[0] = 1'b1; req_wdata[7:0] = 8'h99;
    req_valid = 2'b01;
    waited = 0;
    while (req_ready == 2'b00 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    req_valid = 2'b00;
    waited = 0;
    while (dev_rises != 5'd5 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("abort_at_bit5", 32'(dev_rises), 32'd5);
    abort_frame = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_sel", 32'(spi_sel), 32'd1);
    check("abort_sclk", 32'(spi_clk), 32'd0);
    check("abort_rsp", 32'(rsp_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rsp_any = 1'b0;
    repeat (100) begin
      @(negedge clk);
      rsp_any = rsp_any | (|rsp_valid);
    end
    check("abort_no_rsp", 32'(rsp_any), 32'd0);
    check("abort_no_write", 32'(dev_regs[4]), 32'h00);
    abort_frame = 1'b0;
    // ptr is back at 0, so req0 wins even with req1 pending
    req_addr[2:0] = 3'd1; req_wdata[7:0] = 8'h5A;
    req_valid = 2'b11;
    run_frame(0, 1'b0, rd, lat);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    check("post_abort_frame", 32'(last_frame), 32'h5A03);

    // 5) req1 raised mid-frame then withdrawn before IDLE
    req_addr[2:0] = 3'd7; req_dir[0] = 1'b0;
    req_valid = 2'b01;
    waited = 0;
    while (req_ready == 2'b00 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    r1_before = rsp1_cnt;
    req_valid = 2'b10;
    repeat (20) @(negedge clk);
    req_valid = 2'b01;
    run_frame(0, 1'b0, rd, lat);
    repeat (3) @(negedge clk);
    check("withdraw_no_rsp1", 32'(rsp1_cnt - r1_before), 32'd0);
    check("withdraw_frame", 32'(last_frame), 32'h000E);

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
